// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl shared definitions.
// Register offsets, STATUS fields, priority helper.
package irq_ctrl_pkg;

  localparam int N_SRC = 6;

  localparam logic [4:0] OFF_PEND = 5'h00;
  localparam logic [4:0] OFF_MASK = 5'h04;
  localparam logic [4:0] OFF_MODE = 5'h08;
  localparam logic [4:0] OFF_CTRL = 5'h0C;
  localparam logic [4:0] OFF_STAT = 5'h10;

  localparam int STAT_ACT_LO = 0;
  localparam int STAT_ANY    = 8;
  localparam int STAT_IDX_LO = 10;

  // Index of the lowest set bit; 0 when none set.
  function automatic logic [2:0] lowest_idx(
    input logic [N_SRC-1:0] v
  );
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Per-source synchronizer with rise detect.
// s is the last sync stage; rise = s & ~s_d.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] ff_d, ff_q;
  logic                   sd_d, sd_q;

  // Shift the raw line through the chain.
  always_comb begin
    ff_d = {ff_q[SYNC_STAGES-2:0], a};
    sd_d = ff_q[SYNC_STAGES-1];
  end

  // Synchronizer and delay flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ff_q <= '0;
      sd_q <= 1'b0;
    end else begin
      ff_q <= ff_d;
      sd_q <= sd_d;
    end
  end

  assign s    = ff_q[SYNC_STAGES-1];
  assign rise = s & ~sd_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: pend/mask/mode/GIE
// registers on the M-stage bus, drives HW[5:0].
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_7F20,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_irq,
  input  logic [31:0]      bus_addr,
  input  logic [31:0]      bus_wdata,
  input  logic             bus_we,
  output logic [31:0]      bus_rdata,
  output logic [N_SRC-1:0] hw_int
);

  logic [N_SRC-1:0] s, rise;
  logic [N_SRC-1:0] pend_d, pend_q;
  logic [N_SRC-1:0] mask_d, mask_q;
  logic [N_SRC-1:0] mode_d, mode_q;
  logic [N_SRC-1:0] hw_d, hw_q;
  logic             gie_d, gie_q;

  logic             hit;
  logic [4:0]       off;
  logic             wr;
  logic [N_SRC-1:0] w;
  logic [N_SRC-1:0] act;
  logic             unused;

  for (genvar i = 0; i < N_SRC; i++) begin : g_sync
    irq_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk (clk),
      .reset(reset),
      .a   (src_irq[i]),
      .s   (s[i]),
      .rise(rise[i])
    );
  end

  assign hit    = bus_addr[31:5] == BASE_ADDR[31:5];
  assign off    = {bus_addr[4:2], 2'b00};
  assign wr     = bus_we & hit;
  assign w      = bus_wdata[N_SRC-1:0];
  assign act    = pend_q & mask_q;
  assign unused = ^{bus_addr[1:0], bus_wdata[31:N_SRC]};

  // Register writes and PEND update.
  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    gie_d  = gie_q;
    if (wr && off == OFF_MASK) mask_d = w;
    if (wr && off == OFF_MODE) mode_d = w;
    if (wr && off == OFF_CTRL) gie_d = bus_wdata[0];
    for (int i = 0; i < N_SRC; i++) begin
      // Old mode governs this cycle; a 0->1
      // switch drops stale level state.
      if (!mode_q[i] && mode_d[i]) begin
        pend_d[i] = rise[i];
      end else if (mode_q[i]) begin
        pend_d[i] = rise[i] | (pend_q[i] &
          ~(wr && off == OFF_PEND && w[i]));
      end else begin
        pend_d[i] = s[i];
      end
    end
    hw_d = gie_q ? act : '0;
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
      mask_q <= '0;
      mode_q <= '0;
      gie_q  <= 1'b0;
      hw_q   <= '0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
      mode_q <= mode_d;
      gie_q  <= gie_d;
      hw_q   <= hw_d;
    end
  end

  assign hw_int = hw_q;

  // Read mux.
  always_comb begin
    bus_rdata = '0;
    if (hit) begin
      case (off)
        OFF_PEND: bus_rdata[N_SRC-1:0] = pend_q;
        OFF_MASK: bus_rdata[N_SRC-1:0] = mask_q;
        OFF_MODE: bus_rdata[N_SRC-1:0] = mode_q;
        OFF_CTRL: bus_rdata[0] = gie_q;
        OFF_STAT: begin
          bus_rdata[STAT_ACT_LO +: N_SRC] = act;
          bus_rdata[STAT_ANY] = |act;
          bus_rdata[STAT_IDX_LO +: 3] =
            lowest_idx(act);
        end
        default: bus_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl.
// Inputs change and outputs sample at negedge.
module tb_irq_ctrl;

  localparam logic [31:0] BASE = 32'h0000_7F20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  src_irq = '0;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic        bus_we = 1'b0;
  logic [31:0] bus_rdata;
  logic [5:0]  hw_int;

  int n_cmp = 0;
  int n_bad = 0;

  irq_ctrl u_dut (
    .clk      (clk),
    .reset    (reset),
    .src_irq  (src_irq),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_we   (bus_we),
    .bus_rdata(bus_rdata),
    .hw_int   (hw_int)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
        tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Starts at a negedge; commits at next posedge.
  task automatic wr(
    input logic [4:0]  off,
    input logic [31:0] d
  );
    bus_addr  = BASE + 32'(off);
    bus_wdata = d;
    bus_we    = 1'b1;
    @(negedge clk);
    bus_we    = 1'b0;
  endtask

  task automatic rd(
    input  logic [31:0] a,
    output logic [31:0] d
  );
    bus_we   = 1'b0;
    bus_addr = a;
    #1;
    d = bus_rdata;
  endtask

  logic [31:0] r;

  initial begin
    cyc(2);
    reset = 1'b1;
    cyc(1);

    for (int i = 0; i < 8; i++) begin
      rd(BASE + 32'(i * 4), r);
      chk("rst_rd", r, 32'h0);
    end
    chk("rst_hw", {26'h0, hw_int}, 32'h0);

    src_irq = 6'h3F;
    cyc(6);
    chk("mask0_hw", {26'h0, hw_int}, 32'h0);
    rd(BASE + 32'h00, r);
    chk("lvl_pend", r, 32'h3F);
    src_irq = 6'h00;
    cyc(5);

    wr(5'h04, 32'h01);
    wr(5'h0C, 32'h01);
    wr(5'h08, 32'h00);
    rd(BASE + 32'h24, r);
    chk("miss_rd", r, 32'h0);
    wr(5'h1C, 32'hFF);
    rd(BASE + 32'h04, r);
    chk("mask_rd", r, 32'h01);

    src_irq = 6'h01;
    cyc(3);
    chk("lvl_hw_e3", {26'h0, hw_int}, 32'h0);
    rd(BASE + 32'h00, r);
    chk("lvl_pend_e3", r, 32'h01);
    cyc(1);
    chk("lvl_hw_e4", {26'h0, hw_int}, 32'h01);
    src_irq = 6'h00;
    cyc(3);
    chk("lvl_off_e3", {26'h0, hw_int}, 32'h01);
    cyc(1);
    chk("lvl_off_e4", {26'h0, hw_int}, 32'h0);

    wr(5'h08, 32'h04);
    wr(5'h04, 32'h04);
    src_irq = 6'h04;
    cyc(3);
    src_irq = 6'h00;
    cyc(5);
    rd(BASE + 32'h00, r);
    chk("edge_pend", r, 32'h04);
    chk("edge_hw", {26'h0, hw_int}, 32'h04);
    wr(5'h00, 32'h04);
    rd(BASE + 32'h00, r);
    chk("w1c_pend", r, 32'h0);
    chk("w1c_hw_same", {26'h0, hw_int}, 32'h04);
    cyc(1);
    chk("w1c_hw", {26'h0, hw_int}, 32'h0);

    src_irq = 6'h04;
    cyc(2);
    wr(5'h00, 32'h04);
    rd(BASE + 32'h00, r);
    chk("set_wins", r, 32'h04);
    src_irq = 6'h00;
    cyc(3);

    wr(5'h00, 32'h3F);
    wr(5'h08, 32'h2E);
    wr(5'h04, 32'h28);
    src_irq = 6'h2A;
    cyc(4);
    rd(BASE + 32'h00, r);
    chk("multi_pend", r, 32'h2A);
    rd(BASE + 32'h10, r);
    chk("status", r, 32'h0000_0D28);
    cyc(1);
    chk("multi_hw", {26'h0, hw_int}, 32'h28);

    wr(5'h08, 32'h3F);
    wr(5'h04, 32'h3F);
    src_irq = 6'h3F;
    cyc(4);
    src_irq = 6'h00;
    cyc(4);
    rd(BASE + 32'h00, r);
    chk("full_pend", r, 32'h3F);
    chk("full_hw", {26'h0, hw_int}, 32'h3F);

    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_hw", {26'h0, hw_int}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      rd(BASE + 32'(i * 4), r);
      chk("rst_mid_rd", r, 32'h0);
    end
    cyc(2);
    reset = 1'b1;
    cyc(6);
    chk("post_hw", {26'h0, hw_int}, 32'h0);
    rd(BASE + 32'h00, r);
    chk("post_pend", r, 32'h0);
    rd(BASE + 32'h0C, r);
    chk("post_ctrl", r, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
